bit_collector: RTL and testbench
================================

# bit_collector

Downstream stage of the half-adder/2:1-mux select path. Each cycle it accepts one mux output bit (`y_in`) and its matching half-adder carry bit (`carry_in`) through a valid/ready handshake. It packs `WIDTH` consecutive bits LSB-first into a parallel word and counts the carries seen during that word. The finished word and its carry count are presented on a valid/ready output port and held until consumed.

## Interface
- `WIDTH`, default 8: bits per output word; legal range 2–32.
- `CNT_W`, default 4: width of the carry counter. Constraint: 2^CNT_W − 1 ≥ 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `y_in`/`carry_in` hold a valid bit pair.
- `in_ready` output 1: the block can accept a bit pair this cycle.
- `y_in` input 1: data bit from the mux stage.
- `carry_in` input 1: carry bit from the half-adder stage.
- `out_valid` output 1: `out_word`, `carry_count` and `carry_sat` are valid.
- `out_ready` input 1: downstream consumes the word this cycle.
- `out_word` output `WIDTH`: packed bits; the first accepted bit is at bit 0.
- `carry_count` output `CNT_W`: number of `carry_in`=1 bits in the word, saturating.
- `carry_sat` output 1: `carry_count` saturated during this word.

## Operation
- **States:** FILL and HOLD.
- **Reset:** state FILL, `in_ready`=1, `out_valid`=0, `out_word`=0, `carry_count`=0, `carry_sat`=0, and the bit index `idx`=0.
- **FILL:**
  - `in_ready`=1 and `out_valid`=0.
  - Accept happens when `in_valid`=1.
  - On accept: `out_word[idx]` ← `y_in` and `idx` increments.
  - If `carry_in`=1 and `carry_count` < 2^CNT_W − 1, `carry_count` increments.
  - If `carry_in`=1 and `carry_count` = 2^CNT_W − 1, `carry_count` holds and `carry_sat` ← 1.
  - On the accept where `idx` = WIDTH − 1: `idx` wraps to 0 and the state goes to HOLD.
- **HOLD:**
  - `in_ready`=0 and `out_valid`=1; all outputs are stable.
  - When `out_ready`=1: go to FILL, and clear `out_word`, `carry_count` and `carry_sat`.
- **Simultaneous events:**
  - In HOLD, `in_valid`=1 together with `out_ready`=1 is not accepted, because `in_ready` was 0 that cycle. There is no bypass. The first bit of the next word is accepted no earlier than the cycle after the handoff.
  - In FILL, `out_ready` is ignored.
- **Input during stall:** `in_valid` is low or ignored while `in_ready`=0. No bit is dropped or duplicated, because acceptance requires `in_valid` & `in_ready`.
- **Reset mid-operation:** a partial word is discarded. All registers return to their reset values immediately on `rst_n` falling, independent of `clk`.
- **Decode:** `in_ready` and `out_valid` are decoded from the registered state only. There is no combinational path from `out_ready` to `in_ready`.

## Timing
- **Input throughput:** 1 bit per cycle while in FILL.
- **Output latency:** `out_valid` rises in the cycle after the WIDTH-th accept.
- **Word period:** minimum WIDTH + 1 cycles (WIDTH accepts plus 1 handoff cycle with `out_ready` held at 1).
- **Output stability:** `out_word`, `carry_count` and `carry_sat` do not change while `out_valid`=1 and `out_ready`=0.
- **Idle input:** gaps in `in_valid` stall filling without loss of the partial word.

## Structure
- **Shared package `bit_collector_pkg`:**
  - state enum (FILL, HOLD);
  - default `WIDTH` and `CNT_W` constants;
  - a function returning the saturation value 2^CNT_W − 1.
- **Sub-module `sat_counter`:** parameterised `CNT_W` with ports `clk`, `rst_n`, `clr`, `inc`, `count`, `sat`. It is instantiated once for the carry counter. The packer, index and FSM stay in the top module.

## Test plan
- **Reset value:** assert `rst_n`=0 mid-word after 5 accepts, then release. Required: `out_valid`=0, `in_ready`=1, `carry_count`=0. The next 8 accepts then form a fresh word, with no leftover bits.
- **Basic word:** WIDTH=8; feed `y_in` sequence 1,0,1,1,0,0,1,0 (first to last) with `carry_in`=0, then hold `out_ready`=0 for 3 cycles. Required: `out_word`=8'h4D stable for 3 cycles, `carry_count`=0, `in_ready`=0.
- **Carry count:** WIDTH=8; `carry_in` pattern 1,1,0,1,0,0,0,1. Required: `carry_count`=4 and `carry_sat`=0 at `out_valid`.
- **Saturation:** CNT_W=2, WIDTH=8, `carry_in`=1 for all 8 bits. Required: `carry_count`=3 and `carry_sat`=1. Both clear after the handoff.
- **Gaps and back-to-back:** random `in_valid` gaps, `out_ready` tied 1, 4 words. Required:
  - every bit lands at the correct index;
  - `out_valid` lasts exactly 1 cycle per word;
  - an `in_valid`=1 asserted in the handoff cycle is not accepted.
- **Scoreboard against upstream:** drive `y_in` = selected input of the 2:1 mux (`A^B` ? `I1` : `I0`) and `carry_in` = `A&B` from random `A`, `B`, `I0`, `I1`. Required: `out_word` and `carry_count` match the reference model for 100 words.

Source files
------------

// File: rtl/bit_collector_pkg.sv
// Shared types and constants for the bit collector: FSM states, default
// geometry and the carry-counter saturation value.
package bit_collector_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   // All-ones value of a cnt_w-bit counter; cnt_w = 32 wraps correctly to 32'hFFFF_FFFF.
   function automatic int unsigned sat_val(input int unsigned cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

endpackage

// File: rtl/bit_collector_if.sv
// Bit-pair input handshake and packed-word output handshake of the bit collector.
interface bit_collector_if
   import bit_collector_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic             y_in;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_word;
   logic [CNT_W-1:0] carry_count;
   logic             carry_sat;

   modport master (
      output in_valid, y_in, carry_in, out_ready,
      input  in_ready, out_valid, out_word, carry_count, carry_sat
   );

   modport slave (
      input  in_valid, y_in, carry_in, out_ready,
      output in_ready, out_valid, out_word, carry_count, carry_sat
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat is sticky until the next clear.
module sat_counter
   import bit_collector_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_val(CNT_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (inc) begin
         if (count == MAX) begin
            sat <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/bit_collector.sv
// Packs WIDTH accepted bits LSB-first into a word, counts carries per word and
// holds the result on the output handshake until it is consumed.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FILL  | in_ready=1, accepting bit pairs into out_word[idx]
//   HOLD  | out_valid=1, word and carry count frozen until out_ready
module bit_collector
   import bit_collector_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic              clk,
   input logic              rst_n,
   bit_collector_if.slave   bus
);

   localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] word_q;
   logic             accept;
   logic             clr;
   logic [CNT_W-1:0] carry_count;
   logic             carry_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // out_ready only matters in HOLD, so a handoff never overlaps an accept.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      clr     = 1'b0;
      case (state_q)
         FILL: begin
            if (bus.in_valid) begin
               accept = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               clr     = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (clr) begin
         word_q <= '0;
      end else if (accept) begin
         word_q[idx_q] <= bus.y_in;
         idx_q         <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_carry_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (accept & bus.carry_in),
      .count (carry_count),
      .sat   (carry_sat)
   );

   assign bus.in_ready    = (state_q == FILL);
   assign bus.out_valid   = (state_q == HOLD);
   assign bus.out_word    = word_q;
   assign bus.carry_count = carry_count;
   assign bus.carry_sat   = carry_sat;

endmodule

// File: tb/tb_bit_collector.sv
// Bench for bit_collector: two instances (CNT_W=4 and CNT_W=2) share one stimulus
// stream and are checked every cycle against a queue-based word model.
module tb_bit_collector;

   localparam int WIDTH = 8;
   localparam int MAX_A = 15;
   localparam int MAX_B = 3;

   logic clk;
   logic rst_n;

   bit_collector_if #(.WIDTH(WIDTH), .CNT_W(4)) ifa ();
   bit_collector_if #(.WIDTH(WIDTH), .CNT_W(2)) ifb ();

   bit_collector #(.WIDTH(WIDTH), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   bit_collector #(.WIDTH(WIDTH), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   assign ifb.in_valid  = ifa.in_valid;
   assign ifb.y_in      = ifa.y_in;
   assign ifb.carry_in  = ifa.carry_in;
   assign ifb.out_ready = ifa.out_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
   endtask

   // Model: a word is the list of accepted bits; carries is the raw count of ones.
   bit q[$];
   int carries = 0;
   bit hold    = 0;
   int words   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         carries = 0;
         hold    = 0;
      end else if (!hold) begin
         if (ifa.in_valid === 1'b1) begin
            q.push_back(ifa.y_in);
            carries += int'(ifa.carry_in);
            if (q.size() == WIDTH) hold = 1;
         end
      end else if (ifa.out_ready === 1'b1) begin
         q.delete();
         carries = 0;
         hold    = 0;
         words++;
      end
   end

   function automatic logic [31:0] model_word();
      logic [31:0] w = 0;
      for (int i = 0; i < q.size(); i++) w += 32'(q[i]) << i;
      return w;
   endfunction

   function automatic int sat_min(input int c, input int m);
      return (c > m) ? m : c;
   endfunction

   int ov_cycles = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready_a",  ifa.in_ready,  !hold);
         chk("out_valid_a", ifa.out_valid, hold);
         chk("in_ready_b",  ifb.in_ready,  !hold);
         chk("out_valid_b", ifb.out_valid, hold);
         if (hold) begin
            chk("word_a",  ifa.out_word,    model_word());
            chk("count_a", ifa.carry_count, sat_min(carries, MAX_A));
            chk("sat_a",   ifa.carry_sat,   carries > MAX_A);
            chk("word_b",  ifb.out_word,    model_word());
            chk("count_b", ifb.carry_count, sat_min(carries, MAX_B));
            chk("sat_b",   ifb.carry_sat,   carries > MAX_B);
         end
         if (ifa.out_valid === 1'b1) ov_cycles++;
      end
   end

   task automatic put(input logic y, input logic c);
      @(negedge clk);
      ifa.in_valid = 1'b1;
      ifa.y_in     = y;
      ifa.carry_in = c;
   endtask

   task automatic idle();
      @(negedge clk);
      ifa.in_valid = 1'b0;
      ifa.y_in     = 1'b0;
      ifa.carry_in = 1'b0;
   endtask

   task automatic feed(input logic [7:0] ys, input logic [7:0] cs);
      for (int i = 0; i < WIDTH; i++) put(ys[i], cs[i]);
      idle();
   endtask

   task automatic wait_ov(input string name);
      int n = 0;
      while (ifa.out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout(name);
   endtask

   task automatic handoff();
      @(negedge clk);
      ifa.out_ready = 1'b1;
      @(negedge clk);
      ifa.out_ready = 1'b0;
   endtask

   logic a, b, i0, i1;
   int   w0, ov0, cyc;

   initial begin
      rst_n        = 1'b0;
      ifa.in_valid = 1'b0;
      ifa.y_in     = 1'b0;
      ifa.carry_in = 1'b0;
      ifa.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  ifa.in_ready,    1);
      chk("rst_out_valid", ifa.out_valid,   0);
      chk("rst_word",      ifa.out_word,    0);
      chk("rst_count",     ifa.carry_count, 0);
      rst_n = 1'b1;

      // Partial word then asynchronous reset mid-cycle.
      for (int i = 0; i < 5; i++) put(1'b1, 1'b1);
      @(negedge clk);
      ifa.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", ifa.out_valid,   0);
      chk("midrst_in_ready",  ifa.in_ready,    1);
      chk("midrst_count_a",   ifa.carry_count, 0);
      chk("midrst_count_b",   ifb.carry_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic word 1,0,1,1,0,0,1,0 -> 8'h4D, no leftover ones from the discarded word.
      feed(8'h4D, 8'h00);
      wait_ov("basic_wait");
      for (int k = 0; k < 3; k++) begin
         chk("basic_word",     ifa.out_word,    8'h4D);
         chk("basic_count",    ifa.carry_count, 0);
         chk("basic_in_ready", ifa.in_ready,    0);
         @(negedge clk);
      end
      handoff();

      // Carry pattern 1,1,0,1,0,0,0,1 -> 4 carries; the 2-bit counter saturates at 3.
      feed(8'hA5, 8'h8B);
      wait_ov("carry_wait");
      chk("carry_word_a",  ifa.out_word,    8'hA5);
      chk("carry_count_a", ifa.carry_count, 4);
      chk("carry_sat_a",   ifa.carry_sat,   0);
      chk("carry_count_b", ifb.carry_count, 3);
      chk("carry_sat_b",   ifb.carry_sat,   1);
      handoff();

      // All carries set.
      feed(8'h3C, 8'hFF);
      wait_ov("sat_wait");
      chk("sat_count_b", ifb.carry_count, 3);
      chk("sat_sat_b",   ifb.carry_sat,   1);
      chk("sat_count_a", ifa.carry_count, 8);
      handoff();
      chk("sat_clr_count_b", ifb.carry_count, 0);
      chk("sat_clr_sat_b",   ifb.carry_sat,   0);
      chk("sat_clr_word_a",  ifa.out_word,    0);

      // Random gaps, out_ready tied high, in_valid forced high in every handoff cycle.
      w0  = words;
      ov0 = ov_cycles;
      cyc = 0;
      ifa.out_ready = 1'b1;
      while (words < w0 + 4 && cyc < 400) begin
         @(negedge clk);
         ifa.in_valid = (ifa.out_valid === 1'b1) ? 1'b1 : ($urandom_range(0, 2) != 0);
         ifa.y_in     = 1'($urandom_range(0, 1));
         ifa.carry_in = 1'($urandom_range(0, 1));
         cyc++;
      end
      if (cyc >= 400) timeout("gap_words");
      ifa.out_ready = 1'b0;
      ifa.in_valid  = 1'b0;
      chk("gap_ov_cycles", ov_cycles - ov0, words - w0);

      // Upstream half-adder / 2:1-mux scoreboard over 100 words.
      w0  = words;
      cyc = 0;
      while (words < w0 + 100 && cyc < 4000) begin
         @(negedge clk);
         a  = 1'($urandom_range(0, 1));
         b  = 1'($urandom_range(0, 1));
         i0 = 1'($urandom_range(0, 1));
         i1 = 1'($urandom_range(0, 1));
         ifa.in_valid  = ($urandom_range(0, 4) != 0);
         ifa.y_in      = (a ^ b) ? i1 : i0;
         ifa.carry_in  = a & b;
         ifa.out_ready = ($urandom_range(0, 3) != 0);
         cyc++;
      end
      if (cyc >= 4000) timeout("sb_words");
      @(negedge clk);
      ifa.in_valid  = 1'b0;
      ifa.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
